tone_phase_accumulator: RTL and testbench
=========================================

# tone_phase_accumulator

Per-voice phase accumulator producing the 24-bit `accumulator` word consumed by the triangle tone generator and sibling waveform generators. Advances the phase by a frequency word once per sample tick derived from the system clock. Provides an optional glide (portamento) ramp toward a newly loaded frequency, hard sync, a test/hold bit, and an MSB-rise pulse for syncing other voices.

## Interface
- `CLK_DIV`, 1042, system-clock cycles per sample tick (≥2)
- `ACC_W`, 24, accumulator width; downstream waveform generators require 24
- `FREQ_W`, 16, frequency word width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `freq_word`  in  FREQ_W  target frequency word
- `glide_rate`  in  8  per-tick glide step; 0 = immediate load
- `freq_valid`  in  1  `freq_word`/`glide_rate` valid
- `freq_ready`  out  1  block accepts a new target
- `test`  in  1  level; holds accumulator at zero
- `sync_in`  in  1  hard-sync request pulse from another voice's `msb_rise`
- `accumulator`  out  ACC_W  current phase
- `sample_tick`  out  1  one-cycle pulse; `accumulator` updated this cycle
- `msb_rise`  out  1  one-cycle pulse; `accumulator[ACC_W-1]` went 0→1 at this tick

## Operation
- Divider counts 0..CLK_DIV-1, wraps; tick edge = clock edge where count == CLK_DIV-1.
- Handshake: transfer when `freq_valid && freq_ready`; `glide_rate` sampled with `freq_word`.
- FSM IDLE/GLIDE, registered `cur_freq`, latched `target`, `rate`:
  - IDLE: `freq_ready`=1. Transfer with `glide_rate`==0 → `cur_freq`=`freq_word` next edge, stay IDLE. Transfer with rate≠0 and `freq_word`≠`cur_freq` → latch, GLIDE. Rate≠0 and equal → no-op, stay IDLE.
  - GLIDE: `freq_ready`=0; each tick edge `cur_freq` moves toward `target` by `rate`, saturating at `target` (no overshoot, no wrap). When step result == `target` → IDLE.
- Accumulator at each tick edge, in priority order:
  - `test`=1 → 0.
  - `sync_pending` or `sync_in` this cycle → 0.
  - else `accumulator + zero_ext(cur_freq)` modulo 2^ACC_W.
- `cur_freq` used is the pre-edge value (glide step and phase add on the same edge do not interact).
- `sync_pending` set by `sync_in` between ticks; cleared at every tick edge, including while `test`=1.
- `msb_rise` = new MSB 1 and old MSB 0; never asserted on a zeroing tick.
- `test` does not stop the divider or the glide FSM.

## Timing
- Reset values: `accumulator`=0, `sample_tick`=0, `msb_rise`=0, `freq_ready`=1, `cur_freq`=0, FSM IDLE, divider 0, `sync_pending`=0.
- `accumulator`, `sample_tick`, `msb_rise` all registered and updated on the same tick edge; `sample_tick` and `msb_rise` high exactly one cycle per qualifying tick.
- First tick edge occurs CLK_DIV cycles after reset release.
- Immediate load is visible in the phase increment from the first tick edge after the transfer edge; a load on the tick edge itself takes effect at the following tick.
- `freq_ready` falls on the transfer edge into GLIDE; rises on the tick edge where `cur_freq` reaches `target`.
- Reset assertion mid-glide or mid-interval: all state returns to reset values immediately; pending sync and target discarded.

## Structure
- Shared package `tone_pkg`: `ACC_W`, `FREQ_W` constants, glide FSM state enum.
- Sub-module `sample_tick_divider` (CLK_DIV parameter, `clk`, `rst_n`, `tick` out); reusable by other voices and the output stage.

## Test plan
Bench uses CLK_DIV=4.
- Reset, load 0x0100 rate 0 → `accumulator`=0x000100,0x000200,…; after 4 ticks 0x000400; `sample_tick` every 4th cycle, first at cycle 4.
- Load 0xFFFF rate 0 → tick 128 gives 0x7FFF80, `msb_rise`=0; tick 129 gives 0x80FF7F, `msb_rise`=1; tick 257 wraps to 0x00FEFF.
- From 0x0100, load 0x0110 rate 4 → `cur_freq` 0x0104,0x0108,0x010C,0x0110 on successive ticks; `freq_ready` low throughout, high on 4th tick; then load 0x0102 rate 5 → 0x010B,0x0106,0x0102 (saturated).
- `sync_in` pulse 2 cycles before a tick with `accumulator`=0x000300, freq 0x0100 → that tick gives 0, next 0x000100; `sync_in` coincident with tick edge → also 0.
- `test`=1 for 3 ticks → `accumulator`=0, no `msb_rise`; release → resumes 0x000100 from 0.
- Assert `rst_n`=0 mid-glide → all outputs at reset values immediately, `freq_ready`=1, FSM IDLE after release.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants and glide FSM state type for the tone voice blocks.
package tone_pkg;

  localparam int TONE_ACC_W  = 24;
  localparam int TONE_FREQ_W = 16;

  typedef enum logic [0:0] {
    GLIDE_IDLE = 1'b0,
    GLIDE_RUN  = 1'b1
  } glide_state_e;

endpackage

// File: rtl/sample_tick_divider.sv
// Free-running sample-rate divider; tick is high for the one cycle whose
// closing edge is the sample edge (count == CLK_DIV-1).
module sample_tick_divider #(
  parameter int CLK_DIV = 1042
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next count: wrap after the last value of the interval.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tick is precomputed from the next count so it stays a register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tone_phase_accumulator.sv
// Per-voice phase accumulator with glide toward a new frequency word,
// hard sync, test/hold and an MSB-rise pulse for syncing other voices.
module tone_phase_accumulator
  import tone_pkg::*;
#(
  parameter int CLK_DIV = 1042,
  parameter int ACC_W   = TONE_ACC_W,
  parameter int FREQ_W  = TONE_FREQ_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_word,
  input  logic [7:0]        glide_rate,
  input  logic              freq_valid,
  output logic              freq_ready,
  input  logic              test,
  input  logic              sync_in,
  output logic [ACC_W-1:0]  accumulator,
  output logic              sample_tick,
  output logic              msb_rise
);

  logic              tick_s;
  logic              xfer_s;
  glide_state_e      state_q, state_d;
  logic [FREQ_W-1:0] cur_freq_q, cur_freq_d;
  logic [FREQ_W-1:0] target_q, target_d;
  logic [7:0]        rate_q, rate_d;
  logic [FREQ_W-1:0] rate_ext_s, dist_s, step_s;
  logic              ready_q;
  logic              sync_pending_q, sync_pending_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum_s;
  logic              sample_tick_q;
  logic              msb_rise_q, msb_rise_d;

  sample_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign xfer_s     = freq_valid && ready_q;
  assign rate_ext_s = FREQ_W'(rate_q);

  // One glide step toward the target, clamped so it never overshoots or wraps.
  always_comb begin
    if (cur_freq_q < target_q) begin
      dist_s = target_q - cur_freq_q;
      if (dist_s <= rate_ext_s) begin
        step_s = target_q;
      end else begin
        step_s = cur_freq_q + rate_ext_s;
      end
    end else begin
      dist_s = cur_freq_q - target_q;
      if (dist_s <= rate_ext_s) begin
        step_s = target_q;
      end else begin
        step_s = cur_freq_q - rate_ext_s;
      end
    end
  end

  // Glide FSM: accepts targets in IDLE, steps cur_freq once per tick in RUN.
  always_comb begin
    state_d    = state_q;
    cur_freq_d = cur_freq_q;
    target_d   = target_q;
    rate_d     = rate_q;
    case (state_q)
      GLIDE_IDLE: begin
        if (xfer_s && (glide_rate == 8'd0)) begin
          cur_freq_d = freq_word;
        end else if (xfer_s && (freq_word != cur_freq_q)) begin
          target_d = freq_word;
          rate_d   = glide_rate;
          state_d  = GLIDE_RUN;
        end else begin
          state_d = GLIDE_IDLE;
        end
      end
      GLIDE_RUN: begin
        if (tick_s) begin
          cur_freq_d = step_s;
          state_d    = (step_s == target_q) ? GLIDE_IDLE : GLIDE_RUN;
        end else begin
          state_d = GLIDE_RUN;
        end
      end
      default: begin
        state_d = GLIDE_IDLE;
      end
    endcase
  end

  assign sum_s = acc_q + ACC_W'(cur_freq_q);

  // Phase update on tick edges; test beats sync, sync beats the add.
  always_comb begin
    acc_d          = acc_q;
    msb_rise_d     = 1'b0;
    sync_pending_d = sync_pending_q;
    if (tick_s) begin
      sync_pending_d = 1'b0;
      if (test) begin
        acc_d = {ACC_W{1'b0}};
      end else if (sync_pending_q || sync_in) begin
        acc_d = {ACC_W{1'b0}};
      end else begin
        acc_d      = sum_s;
        msb_rise_d = sum_s[ACC_W-1] & ~acc_q[ACC_W-1];
      end
    end else begin
      sync_pending_d = sync_pending_q | sync_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GLIDE_IDLE;
      cur_freq_q     <= {FREQ_W{1'b0}};
      target_q       <= {FREQ_W{1'b0}};
      rate_q         <= 8'd0;
      ready_q        <= 1'b1;
      sync_pending_q <= 1'b0;
      acc_q          <= {ACC_W{1'b0}};
      sample_tick_q  <= 1'b0;
      msb_rise_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_freq_q     <= cur_freq_d;
      target_q       <= target_d;
      rate_q         <= rate_d;
      ready_q        <= (state_d == GLIDE_IDLE);
      sync_pending_q <= sync_pending_d;
      acc_q          <= acc_d;
      sample_tick_q  <= tick_s;
      msb_rise_q     <= msb_rise_d;
    end
  end

  assign freq_ready  = ready_q;
  assign accumulator = acc_q;
  assign sample_tick = sample_tick_q;
  assign msb_rise    = msb_rise_q;

endmodule

// File: tb/tb_tone_phase_accumulator.sv
// Directed self-checking bench for tone_phase_accumulator with CLK_DIV=4.
module tb_tone_phase_accumulator;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] freq_word;
  logic [7:0]  glide_rate;
  logic        freq_valid;
  logic        freq_ready;
  logic        test;
  logic        sync_in;
  logic [23:0] accumulator;
  logic        sample_tick;
  logic        msb_rise;

  int checks = 0;
  int errors = 0;

  tone_phase_accumulator #(.CLK_DIV(CLK_DIV), .ACC_W(24), .FREQ_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .freq_word  (freq_word),
    .glide_rate (glide_rate),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .test       (test),
    .sync_in    (sync_in),
    .accumulator(accumulator),
    .sample_tick(sample_tick),
    .msb_rise   (msb_rise)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the negedge following the next sample tick (bounded).
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!sample_tick && cycles < 20);
    checks++;
    if (sample_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: sample_tick=%b after %0d cycles, required 1", sample_tick, cycles);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    freq_valid = 1'b0; freq_word = 16'h0; glide_rate = 8'h0;
    test = 1'b0; sync_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [15:0] f, input logic [7:0] r);
    freq_word = f; glide_rate = r; freq_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_t;
    rst_n = 1'b0;
    freq_valid = 1'b0; freq_word = 16'h0; glide_rate = 8'h0;
    test = 1'b0; sync_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (accumulator !== 24'h0 || sample_tick !== 1'b0 || msb_rise !== 1'b0 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: acc=%h tick=%b msb=%b ready=%b, required 000000 0 0 1",
               accumulator, sample_tick, msb_rise, freq_ready);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= CLK_DIV; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_t = (i == CLK_DIV) ? 1'b1 : 1'b0;
      checks++;
      if (sample_tick !== exp_t) begin
        errors++;
        $display("FAIL first_tick: cycle %0d sample_tick=%b, required %b", i, sample_tick, exp_t);
      end
    end
    checks++;
    if (accumulator !== 24'h0) begin
      errors++;
      $display("FAIL first_tick_acc: acc=%h, required 000000", accumulator);
    end
  endtask

  task automatic test_load_basic();
    logic [23:0] exp_tab [4] = '{24'h000100, 24'h000200, 24'h000300, 24'h000400};
    int cyc;
    load(16'h0100, 8'd0);
    for (int k = 0; k < 4; k++) begin
      wait_tick(cyc);
      checks++;
      if (accumulator !== exp_tab[k]) begin
        errors++;
        $display("FAIL load_basic: tick %0d acc=%h, required %h", k + 1, accumulator, exp_tab[k]);
      end
      if (k > 0) begin
        checks++;
        if (cyc != CLK_DIV) begin
          errors++;
          $display("FAIL tick_period: %0d cycles between ticks, required %0d", cyc, CLK_DIV);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_acc, nxt;
    logic        exp_msb;
    int          cyc;
    apply_reset();
    load(16'hFFFF, 8'd0);
    exp_acc = 24'h0;
    for (int n = 1; n <= 257; n++) begin
      wait_tick(cyc);
      nxt     = exp_acc + 24'h00FFFF;
      exp_msb = nxt[23] & ~exp_acc[23];
      exp_acc = nxt;
      checks++;
      if (accumulator !== exp_acc || msb_rise !== exp_msb) begin
        errors++;
        $display("FAIL wrap_model: tick %0d acc=%h msb=%b, required %h %b",
                 n, accumulator, msb_rise, exp_acc, exp_msb);
      end
      if (n == 128) begin
        checks++;
        if (accumulator !== 24'h7FFF80 || msb_rise !== 1'b0) begin
          errors++;
          $display("FAIL wrap_t128: acc=%h msb=%b, required 7fff80 0", accumulator, msb_rise);
        end
      end
      if (n == 129) begin
        checks++;
        if (accumulator !== 24'h80FF7F || msb_rise !== 1'b1) begin
          errors++;
          $display("FAIL wrap_t129: acc=%h msb=%b, required 80ff7f 1", accumulator, msb_rise);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (msb_rise !== 1'b0 || sample_tick !== 1'b0) begin
          errors++;
          $display("FAIL pulse_width: msb=%b tick=%b one cycle later, required 0 0", msb_rise, sample_tick);
        end
      end
      if (n == 257) begin
        checks++;
        if (accumulator !== 24'h00FEFF) begin
          errors++;
          $display("FAIL wrap_t257: acc=%h, required 00feff", accumulator);
        end
      end
    end
  endtask

  task automatic test_glide();
    logic [15:0] up_d  [5] = '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0110};
    logic        up_r  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] dn_d  [4] = '{16'h0110, 16'h010B, 16'h0106, 16'h0102};
    logic        dn_r  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] prev, delta;
    int          cyc;
    apply_reset();
    load(16'h0100, 8'd0);
    wait_tick(cyc);
    load(16'h0110, 8'd4);
    checks++;
    if (freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL glide_up_ready_fall: ready=%b, required 0", freq_ready);
    end
    for (int k = 0; k < 5; k++) begin
      prev = accumulator;
      wait_tick(cyc);
      delta = accumulator - prev;
      checks++;
      if (delta !== {8'h00, up_d[k]} || freq_ready !== up_r[k]) begin
        errors++;
        $display("FAIL glide_up: tick %0d step=%h ready=%b, required %h %b",
                 k + 1, delta, freq_ready, up_d[k], up_r[k]);
      end
    end
    load(16'h0102, 8'd5);
    checks++;
    if (freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL glide_dn_ready_fall: ready=%b, required 0", freq_ready);
    end
    for (int k = 0; k < 4; k++) begin
      prev = accumulator;
      wait_tick(cyc);
      delta = accumulator - prev;
      checks++;
      if (delta !== {8'h00, dn_d[k]} || freq_ready !== dn_r[k]) begin
        errors++;
        $display("FAIL glide_dn: tick %0d step=%h ready=%b, required %h %b",
                 k + 1, delta, freq_ready, dn_d[k], dn_r[k]);
      end
    end
    load(16'h0102, 8'd7);
    prev = accumulator;
    wait_tick(cyc);
    delta = accumulator - prev;
    checks++;
    if (freq_ready !== 1'b1 || delta !== 24'h000102) begin
      errors++;
      $display("FAIL glide_noop: ready=%b step=%h, required 1 000102", freq_ready, delta);
    end
  endtask

  task automatic test_sync();
    int cyc;
    apply_reset();
    load(16'h0100, 8'd0);
    repeat (3) wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h000300) begin
      errors++;
      $display("FAIL sync_pre: acc=%h, required 000300", accumulator);
    end
    @(posedge clk);
    @(negedge clk);
    sync_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync_in = 1'b0;
    wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h0) begin
      errors++;
      $display("FAIL sync_pending: acc=%h, required 000000", accumulator);
    end
    wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h000100) begin
      errors++;
      $display("FAIL sync_resume: acc=%h, required 000100", accumulator);
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    sync_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync_in = 1'b0;
    checks++;
    if (sample_tick !== 1'b1 || accumulator !== 24'h0) begin
      errors++;
      $display("FAIL sync_coincident: tick=%b acc=%h, required 1 000000", sample_tick, accumulator);
    end
    wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h000100) begin
      errors++;
      $display("FAIL sync_coinc_resume: acc=%h, required 000100", accumulator);
    end
  endtask

  task automatic test_hold();
    int cyc;
    test = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(posedge clk);
        @(negedge clk);
        sync_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sync_in = 1'b0;
      end
      wait_tick(cyc);
      checks++;
      if (accumulator !== 24'h0 || msb_rise !== 1'b0) begin
        errors++;
        $display("FAIL test_hold: tick %0d acc=%h msb=%b, required 000000 0", k + 1, accumulator, msb_rise);
      end
    end
    test = 1'b0;
    wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h000100) begin
      errors++;
      $display("FAIL test_release: acc=%h, required 000100", accumulator);
    end
  endtask

  task automatic test_reset_mid_glide();
    int cyc;
    apply_reset();
    load(16'h0100, 8'd0);
    wait_tick(cyc);
    load(16'h2000, 8'd1);
    repeat (2) wait_tick(cyc);
    checks++;
    if (freq_ready !== 1'b0 || accumulator !== 24'h000301) begin
      errors++;
      $display("FAIL mid_glide_pre: ready=%b acc=%h, required 0 000301", freq_ready, accumulator);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (accumulator !== 24'h0 || sample_tick !== 1'b0 || msb_rise !== 1'b0 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: acc=%h tick=%b msb=%b ready=%b, required 000000 0 0 1",
               accumulator, sample_tick, msb_rise, freq_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(cyc);
    checks++;
    if (cyc != CLK_DIV || accumulator !== 24'h0 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: cycles=%0d acc=%h ready=%b, required %0d 000000 1",
               cyc, accumulator, freq_ready, CLK_DIV);
    end
    load(16'h0100, 8'd0);
    wait_tick(cyc);
    checks++;
    if (accumulator !== 24'h000100 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load: acc=%h ready=%b, required 000100 1", accumulator, freq_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap();
    test_glide();
    test_sync();
    test_hold();
    test_reset_mid_glide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
